// File: rtl/sync_frame_controller.sv
// sync_frame_controller: qualifies correlator peaks, fires the one-cycle sync
// trigger, tracks delivered symbols on the synchronizer output stream, runs
// the capture watchdog and the post-frame guard, and keeps frame/drop status.
// Build option: define SYNC_CTRL_DROP_CNT_EN to keep the busy-drop counter;
// left undefined, o_drop_count is tied to zero.
module sync_frame_controller #(
    parameter int G_SYM_W = 4,
    parameter int G_CNT_W = 16
) (
    input  logic               axis_aclk,
    input  logic               axis_rst,
    input  logic               i_enable,
    input  logic               i_peak_valid,
    input  logic [31:0]        i_peak_metric,
    input  logic [31:0]        i_threshold,
    input  logic [G_SYM_W-1:0] i_symbols,
    input  logic [31:0]        i_guard_cycles,
    input  logic [31:0]        i_timeout_cycles,
    input  logic               i_mon_tvalid,
    input  logic               i_mon_tready,
    input  logic               i_mon_tlast,
    output logic               o_max_sync,
    output logic               o_busy,
    output logic               o_frame_done,
    output logic               o_frame_timeout,
    output logic [G_CNT_W-1:0] o_frame_count,
    output logic [G_CNT_W-1:0] o_drop_count,
    output logic [1:0]         o_state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_PEAK = 2'd1,
        S_CAPTURE   = 2'd2,
        S_GUARD     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    // target holds preamble + data symbols, so it needs one extra bit
    logic [G_SYM_W:0]   target_q, target_d;
    logic [G_SYM_W:0]   sym_cnt_q, sym_cnt_d;
    logic [31:0]        tmo_q, tmo_d;
    logic [31:0]        wd_q, wd_d;
    logic [31:0]        guard_q, guard_d;
    logic [G_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               sync_q, sync_d;
    logic               done_q, done_d;
    logic               tout_q, tout_d;

    logic               peak_qual;
    logic               sym_beat;
    logic               sym_hit;
    logic               wd_hit;
    logic [G_SYM_W:0]   sym_inc;
    logic [31:0]        wd_inc;

    assign peak_qual = i_peak_valid && (i_peak_metric >= i_threshold);
    assign sym_beat  = i_mon_tvalid && i_mon_tready && i_mon_tlast;
    assign sym_inc   = sym_cnt_q + (G_SYM_W+1)'(1);
    assign sym_hit   = sym_beat && (sym_inc == target_q);
    assign wd_inc    = wd_q + 32'd1;
    // a zero timeout latched at the trigger disables the watchdog
    assign wd_hit    = (tmo_q != 32'd0) && (wd_inc == tmo_q);

    assign o_busy          = (state_q == S_CAPTURE) || (state_q == S_GUARD);
    assign o_state         = state_q;
    assign o_max_sync      = sync_q;
    assign o_frame_done    = done_q;
    assign o_frame_timeout = tout_q;
    assign o_frame_count   = frame_cnt_q;

    // next-state, per-frame counters and pulse requests
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        sym_cnt_d   = sym_cnt_q;
        tmo_d       = tmo_q;
        wd_d        = wd_q;
        guard_d     = guard_q;
        frame_cnt_d = frame_cnt_q;
        sync_d      = 1'b0;
        done_d      = 1'b0;
        tout_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_enable) state_d = S_WAIT_PEAK;
            end
            S_WAIT_PEAK: begin
                // a peak beats a simultaneous enable drop
                if (peak_qual) begin
                    state_d   = S_CAPTURE;
                    sync_d    = 1'b1;
                    target_d  = {1'b0, i_symbols} + (G_SYM_W+1)'(1);
                    sym_cnt_d = '0;
                    tmo_d     = i_timeout_cycles;
                    wd_d      = '0;
                end else if (!i_enable) begin
                    state_d = S_IDLE;
                end
            end
            S_CAPTURE: begin
                if (sym_beat) sym_cnt_d = sym_inc;
                if (tmo_q != 32'd0) wd_d = wd_inc;
                // completion has priority over a coincident timeout
                if (sym_hit) begin
                    done_d  = 1'b1;
                    state_d = S_GUARD;
                    guard_d = i_guard_cycles;
                    if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + G_CNT_W'(1);
                end else if (wd_hit) begin
                    tout_d  = 1'b1;
                    state_d = S_GUARD;
                    guard_d = i_guard_cycles;
                end
            end
            S_GUARD: begin
                // guard of 0 or 1 both give a single GUARD cycle
                if (guard_q <= 32'd1) state_d = i_enable ? S_WAIT_PEAK : S_IDLE;
                else                  guard_d = guard_q - 32'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and counter registers, cleared by synchronous reset
    always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            sym_cnt_q   <= '0;
            tmo_q       <= '0;
            wd_q        <= '0;
            guard_q     <= '0;
            frame_cnt_q <= '0;
            sync_q      <= 1'b0;
            done_q      <= 1'b0;
            tout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            sym_cnt_q   <= sym_cnt_d;
            tmo_q       <= tmo_d;
            wd_q        <= wd_d;
            guard_q     <= guard_d;
            frame_cnt_q <= frame_cnt_d;
            sync_q      <= sync_d;
            done_q      <= done_d;
            tout_q      <= tout_d;
        end
    end

`ifdef SYNC_CTRL_DROP_CNT_EN
    logic [G_CNT_W-1:0] drop_cnt_q;

    // count qualified peaks that arrive while a frame is in flight
    always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
            drop_cnt_q <= '0;
        end else if (peak_qual && o_busy && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + G_CNT_W'(1);
        end
    end

    assign o_drop_count = drop_cnt_q;
`else
    assign o_drop_count = '0;
`endif

endmodule
